huffman_sched: RTL and testbench
================================

Name: huffman_sched

Overview:
Frame-level scheduler sharing one huffman coding core between two pixel sources. Arbitrates whole frames round-robin, filters and forwards symbols to the core's gray_valid/gray_data input, and tracks the core's CNT_valid/code_valid progress. Pulses a completion strobe per frame, then re-initialises the core through its active-high reset so it is ready for the next frame. Sits between the image-source front ends and the huffman core.

Parameters:
MAX_PIX, 100, maximum symbols forwarded per frame; must be at most 255 because core counters are 8-bit.
CLR_CYCLES, 2, number of cycles core_reset is held high between frames; minimum 1.
TIMEOUT_CYC, 1023, watchdog limit in cycles; used only with HUFF_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  2  per-requester frame request; level, held until done
gnt  out  2  one-hot grant; held from grant until the done cycle
src_valid  in  2  per-requester symbol valid; sampled only while gnt[i]=1
src_data0  in  8  requester 0 symbol
src_data1  in  8  requester 1 symbol
src_last  in  2  marks the final symbol of the frame; qualified by src_valid
core_reset  out  1  active-high reset to the huffman core
core_gray_valid  out  1  to core gray_valid
core_gray_data  out  8  to core gray_data
core_cnt_valid  in  1  from core CNT_valid
core_code_valid  in  1  from core code_valid
done  out  1  one-cycle frame-complete pulse
done_id  out  1  requester served; valid with done
err  out  3  [0] illegal symbol dropped, [1] MAX_PIX overflow, [2] timeout; valid with done

Behaviour:
- Reset: state=CLEAR, clear counter=0, core_reset=1, gnt=0, core_gray_valid=0, core_gray_data=0, done=0, done_id=0, err=0, rr pointer=0.
- CLEAR: core_reset=1 for CLR_CYCLES cycles, then go to IDLE with core_reset=0. After reset release, the core stays held for CLR_CYCLES cycles.
- IDLE: if exactly one req bit is set, grant it. If both are set, grant the requester not served last; the first grant after reset goes to 0. gnt is registered, so it is visible 1 cycle after the IDLE cycle that saw req. Go to STREAM and clear the pixel count and err.
- STREAM: a symbol is accepted when gnt[i]&src_valid[i].
  - Legal symbols are 1..6. A legal symbol with count<MAX_PIX is forwarded registered: core_gray_valid/core_gray_data appear 1 cycle later and count increments.
  - An illegal symbol is dropped and sets err[0].
  - A legal symbol arriving with count==MAX_PIX is dropped and sets err[1].
  - core_gray_valid is 0 in any cycle without a forwarded symbol.
  - An accepted src_last ends the stream. If count (including the last symbol) is greater than 0, go to WAIT_CNT. If it is 0, go to DONE directly, because the core would never assert CNT_valid.
- WAIT_CNT: core_gray_valid=0. When core_cnt_valid=1, go to WAIT_CODE.
- WAIT_CODE: when core_code_valid=1, go to DONE.
- DONE: single cycle. done=1, done_id=served id, err presented, gnt->0, rr pointer=served id. Core HC/M outputs are stable during this cycle; the consumer samples them here. Next state is CLEAR.
- req dropping mid-frame is ignored; the frame completes normally. src_valid on a non-granted requester is ignored.
- reset_n asserted mid-frame: immediate return to reset values. The core is re-cleared through CLEAR.

Optional Feature:
HUFF_TIMEOUT_EN:
- Defined: a watchdog counter runs in WAIT_CNT and WAIT_CODE and clears on state entry. Reaching TIMEOUT_CYC sets err[2] and forces DONE.
- Undefined: no counter is built, err[2] is tied to 0, and the block waits indefinitely.

Decomposition:
- Package huffman_pkg: state enum (CLEAR, IDLE, STREAM, WAIT_CNT, WAIT_CODE, DONE), SYM_MIN=1, SYM_MAX=6, err bit index constants.
- One sub-module, huffman_rr_arb: 2-way round-robin arbiter taking req and rr pointer and producing a one-hot grant.
- FSM, filtering and counters stay in huffman_sched.

Test Plan:
- Reset release: core_reset stays high for exactly 2 cycles, then goes low. With req=01 after that, gnt=01 one cycle later.
- Requester 0 sends 100 legal symbols, last on the 100th, with the core model responding. Expect 100 core_gray_valid pulses with matching data, then done=1, done_id=0, err=000, then core_reset high for 2 cycles.
- Both req held continuously across 3 frames: grants go 0,1,0, and done_id follows the same order.
- Frame symbols 3,0,7,5(last): only 3 and 5 are forwarded; done arrives with err=001.
- Frame of 102 legal symbols: 100 forwarded, err=010. Separately, a frame with only illegal symbols (0, last): no core_gray_valid, done with err=001, and WAIT_CNT is skipped.
- With HUFF_TIMEOUT_EN defined and core_code_valid stuck at 0: done arrives 1023 cycles after entering WAIT_CODE, with err[2]=1. reset_n pulsed mid-STREAM: gnt=0 and core_reset=1 immediately.

Source files
------------

// File: rtl/huffman_pkg.sv
// ---------------------------------------------------------------------------
// huffman_pkg
// Shared types and constants for the huffman frame scheduler.
//   state_t      : scheduler FSM states
//   NUM_REQ      : number of pixel sources sharing the core
//   SYM_MIN/MAX  : legal symbol range accepted by the huffman core
//   ERR_*        : bit positions inside the err vector
//   sym_legal()  : legal-symbol test used by the filter
// ---------------------------------------------------------------------------
package huffman_pkg;

    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        IDLE      = 3'd1,
        STREAM    = 3'd2,
        WAIT_CNT  = 3'd3,
        WAIT_CODE = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam int NUM_REQ = 2;

    localparam logic [7:0] SYM_MIN = 8'd1;
    localparam logic [7:0] SYM_MAX = 8'd6;

    localparam int ERR_ILLEGAL  = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_TIMEOUT  = 2;

    function automatic logic sym_legal(input logic [7:0] sym);
        return (sym >= SYM_MIN) && (sym <= SYM_MAX);
    endfunction

endpackage

// File: rtl/huffman_rr_arb.sv
// ---------------------------------------------------------------------------
// huffman_rr_arb
// Two-way round-robin arbiter (purely combinational).
//   req      in  2 : request levels
//   rr_ptr   in  1 : requester served most recently
//   rr_valid in  1 : rr_ptr is meaningful (a frame has completed since reset)
//   grant    out 2 : one-hot grant, zero when nothing is requested
// A single requester always wins. On a tie the requester not served last
// wins; before any frame has completed, requester 0 wins the tie.
// ---------------------------------------------------------------------------
module huffman_rr_arb
    import huffman_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_ptr,
    input  logic               rr_valid,
    output logic [NUM_REQ-1:0] grant
);

    logic prio;

    // Requester that wins when both are asking.
    assign prio = rr_valid ? ~rr_ptr : 1'b0;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/huffman_sched.sv
// ---------------------------------------------------------------------------
// huffman_sched
// Frame-level scheduler sharing one huffman core between two pixel sources.
// Grants whole frames round-robin, filters symbols onto the core input,
// follows the core's CNT_valid/code_valid progress, pulses done per frame
// and then re-clears the core through core_reset.
//
// Ports:
//   clk, reset_n       : clock (rising edge), asynchronous active-low reset
//   req[1:0]           : frame request levels
//   gnt[1:0]           : one-hot grant, registered, dropped for the done cycle
//   src_valid[1:0]     : symbol valid per source (used only while granted)
//   src_data0/1[7:0]   : symbols from source 0 / 1
//   src_last[1:0]      : final symbol of the frame, qualified by src_valid
//   core_reset         : active-high reset to the huffman core
//   core_gray_valid    : symbol strobe to the core (one cycle after accept)
//   core_gray_data     : symbol to the core
//   core_cnt_valid     : core CNT_valid
//   core_code_valid    : core code_valid
//   done, done_id      : one-cycle frame-complete pulse and served source
//   err[2:0]           : [0] illegal symbol, [1] overflow, [2] timeout
//
// Optional build macro HUFF_TIMEOUT_EN: adds a watchdog over the two core
// wait states that forces completion with err[2] after TIMEOUT_CYC cycles.
// Without it the scheduler waits on the core indefinitely and err[2] is 0.
// ---------------------------------------------------------------------------
module huffman_sched
    import huffman_pkg::*;
#(
    parameter int MAX_PIX     = 100,
    parameter int CLR_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 1023
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic [NUM_REQ-1:0] src_valid,
    input  logic [7:0]         src_data0,
    input  logic [7:0]         src_data1,
    input  logic [NUM_REQ-1:0] src_last,
    output logic               core_reset,
    output logic               core_gray_valid,
    output logic [7:0]         core_gray_data,
    input  logic               core_cnt_valid,
    input  logic               core_code_valid,
    output logic               done,
    output logic               done_id,
    output logic [2:0]         err
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    state_t             state;
    state_t             next_state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [7:0]         pix_cnt;
    logic [2:0]         err_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               served;
    logic               rr_ptr;
    logic               rr_valid;
    logic               vld_p1;
    logic [7:0]         gray_p1;

    logic               sel;
    logic               acc;
    logic [7:0]         sym;
    logic               is_last;
    logic               legal;
    logic               room;
    logic               fwd;
    logic [7:0]         pix_next;
    logic               clr_done;
    logic               wd_expired;
    logic               timeout_hit;

    huffman_rr_arb u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .rr_valid (rr_valid),
        .grant    (arb_gnt)
    );

    // Symbol filter: the grant is one-hot, so gnt_r[1] selects the source.
    assign sel      = gnt_r[1];
    assign acc      = (state == STREAM) && |(gnt_r & src_valid);
    assign sym      = sel ? src_data1 : src_data0;
    assign is_last  = acc && (sel ? src_last[1] : src_last[0]);
    assign legal    = sym_legal(sym);
    assign room     = pix_cnt < 8'(MAX_PIX);
    assign fwd      = acc && legal && room;
    assign pix_next = pix_cnt + 8'(fwd);
    assign clr_done = clr_cnt == CLR_W'(CLR_CYCLES - 1);

`ifdef HUFF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;

    assign waiting    = (state == WAIT_CNT) || (state == WAIT_CODE);
    assign wd_expired = waiting && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Restarts on every state change so each wait state gets a full budget.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (next_state != state) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    // No watchdog: the limit can never be reached.
    assign wd_expired = (TIMEOUT_CYC < 0);
`endif

    // A forced exit, as opposed to the core finishing in the same cycle.
    assign timeout_hit = wd_expired && (next_state == DONE) &&
                         !((state == WAIT_CODE) && core_code_valid);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:     if (clr_done) next_state = IDLE;
            IDLE:      if (|req) next_state = STREAM;
            STREAM: begin
                // An empty frame never makes the core raise CNT_valid.
                if (is_last) next_state = (pix_next != 8'd0) ? WAIT_CNT : DONE;
            end
            WAIT_CNT: begin
                if (core_cnt_valid)  next_state = WAIT_CODE;
                else if (wd_expired) next_state = DONE;
            end
            WAIT_CODE: begin
                if (core_code_valid || wd_expired) next_state = DONE;
            end
            DONE:      next_state = CLEAR;
            default:   next_state = CLEAR;
        endcase
    end

    // Outputs
    always_comb begin
        core_reset      = (state == CLEAR);
        done            = (state == DONE);
        done_id         = (state == DONE) ? served : 1'b0;
        err             = (state == DONE) ? err_r : 3'b000;
        gnt             = gnt_r;
        core_gray_valid = vld_p1;
        core_gray_data  = gray_p1;
    end

    // Counters, grant, error flags and the forwarding stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt  <= '0;
            pix_cnt  <= '0;
            err_r    <= '0;
            gnt_r    <= '0;
            served   <= 1'b0;
            rr_ptr   <= 1'b0;
            rr_valid <= 1'b0;
            vld_p1   <= 1'b0;
            gray_p1  <= '0;
        end else begin
            clr_cnt <= (state == CLEAR && !clr_done) ? clr_cnt + CLR_W'(1) : '0;
            vld_p1  <= fwd;
            if (fwd) gray_p1 <= sym;

            case (state)
                IDLE: begin
                    if (next_state == STREAM) begin
                        gnt_r   <= arb_gnt;
                        served  <= arb_gnt[1];
                        pix_cnt <= '0;
                        err_r   <= '0;
                    end
                end
                STREAM: begin
                    pix_cnt <= pix_next;
                    if (acc && !legal)         err_r[ERR_ILLEGAL]  <= 1'b1;
                    if (acc && legal && !room) err_r[ERR_OVERFLOW] <= 1'b1;
                end
                WAIT_CNT, WAIT_CODE: begin
                    if (timeout_hit) err_r[ERR_TIMEOUT] <= 1'b1;
                end
                DONE: begin
                    rr_ptr   <= served;
                    rr_valid <= 1'b1;
                end
                default: ;
            endcase

            // Grant is released for the done cycle itself.
            if (next_state == DONE) gnt_r <= '0;
        end
    end

endmodule

// File: tb/tb_huffman_sched.sv
module tb_huffman_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] gnt;
    logic [1:0] src_valid = '0;
    logic [7:0] src_data0 = '0;
    logic [7:0] src_data1 = '0;
    logic [1:0] src_last = '0;
    logic       core_reset;
    logic       core_gray_valid;
    logic [7:0] core_gray_data;
    logic       core_cnt_valid = 1'b0;
    logic       core_code_valid = 1'b0;
    logic       done;
    logic       done_id;
    logic [2:0] err;

    huffman_sched dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .gnt             (gnt),
        .src_valid       (src_valid),
        .src_data0       (src_data0),
        .src_data1       (src_data1),
        .src_last        (src_last),
        .core_reset      (core_reset),
        .core_gray_valid (core_gray_valid),
        .core_gray_data  (core_gray_data),
        .core_cnt_valid  (core_cnt_valid),
        .core_code_valid (core_code_valid),
        .done            (done),
        .done_id         (done_id),
        .err             (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Everything the core receives, in order.
    int fwd_q[$];
    always @(negedge clk) begin
        if (reset_n && core_gray_valid) fwd_q.push_back(int'(core_gray_data));
    end

    // Reference model state: who was served last, and whether anyone was yet.
    int last_srv = 0;
    bit has_srv  = 1'b0;
    int sym_q[$];
    int done_wait;

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return has_srv ? 1 - last_srv : 0;
    endfunction

    task automatic drive(input int w, input bit v, input int d, input bit l);
        logic [7:0] nd;
        logic       nv, nl;
        nd = 8'($urandom_range(0, 255));
        nv = 1'($urandom_range(0, 1));
        nl = 1'($urandom_range(0, 1));
        if (w == 0) begin
            src_valid = {nv, v}; src_last = {nl, l};
            src_data0 = 8'(d);   src_data1 = nd;
        end else begin
            src_valid = {v, nv}; src_last = {l, nl};
            src_data1 = 8'(d);   src_data0 = nd;
        end
    endtask

    // mode 0: core answers; 1: core silent; 2: CNT_valid only (watchdog case)
    task automatic run_frame(input string tag, input int mode, input bit keep_req);
        int  w, e, nbad, n;
        int  exp_q[$];
        bit  seen;

        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (gnt != 2'b00) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_gnt_seen"}, 32'(seen), 1);
        w = pick(req);
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << w));

        e = 0;
        foreach (sym_q[i]) begin
            if (sym_q[i] >= 1 && sym_q[i] <= 6) begin
                if (exp_q.size() < 100) exp_q.push_back(sym_q[i]);
                else e |= 2;
            end else begin
                e |= 1;
            end
        end
        if (mode == 2) e |= 4;

        fwd_q.delete();
        if (mode == 2) core_cnt_valid = 1'b1;
        @(posedge clk) #1;
        n = sym_q.size();
        foreach (sym_q[i]) begin
            repeat ($urandom_range(0, 2)) begin
                drive(w, 1'b0, 0, 1'b0);
                @(posedge clk) #1;
            end
            drive(w, 1'b1, sym_q[i], i == n - 1);
            @(posedge clk) #1;
        end
        src_valid = '0;
        src_last  = '0;
        if (mode == 0) begin core_cnt_valid = 1'b1; core_code_valid = 1'b1; end

        seen = 1'b0;
        done_wait = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; done_wait = c; break; end
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        chk({tag, "_done_id"}, 32'(done_id), 32'(w));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_fwd_cnt"}, 32'(fwd_q.size()), 32'(exp_q.size()));
        nbad = 0;
        for (int i = 0; i < fwd_q.size() && i < exp_q.size(); i++)
            if (fwd_q[i] != exp_q[i]) nbad++;
        chk({tag, "_fwd_data_bad"}, 32'(nbad), 0);

        last_srv = w;
        has_srv  = 1'b1;
        core_cnt_valid  = 1'b0;
        core_code_valid = 1'b0;
        if (!keep_req) req[w] = 1'b0;

        @(negedge clk); chk({tag, "_clr0"}, 32'(core_reset), 1);
        @(negedge clk); chk({tag, "_clr1"}, 32'(core_reset), 1);
        @(negedge clk); chk({tag, "_clr_end"}, 32'(core_reset), 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_gray_valid", 32'(core_gray_valid), 0);
        chk("rst_gray_data", 32'(core_gray_data), 0);

        // Core held for exactly two cycles after release
        reset_n = 1'b1;
        #1 chk("rel_clr0", 32'(core_reset), 1);
        @(negedge clk); chk("rel_clr1", 32'(core_reset), 1);
        @(negedge clk); chk("rel_clr_end", 32'(core_reset), 0);
        req = 2'b01;
        @(negedge clk); chk("first_gnt", 32'(gnt), 1);

        // Full 100-symbol frame from requester 0
        sym_q.delete();
        repeat (100) sym_q.push_back($urandom_range(1, 6));
        run_frame("f100", 0, 1'b0);

        // Illegal symbols filtered
        req = 2'b01;
        sym_q = '{3, 0, 7, 5};
        run_frame("filt", 0, 1'b0);

        // Overflow: 102 legal symbols
        req = 2'b10;
        sym_q.delete();
        repeat (102) sym_q.push_back($urandom_range(1, 6));
        run_frame("ovf", 0, 1'b0);

        // Only an illegal symbol: straight to done without the core
        req = 2'b01;
        sym_q = '{0};
        run_frame("empty", 1, 1'b0);
        chk("empty_skip_wait", 32'(done_wait), 0);

        // Random frames and request patterns
        for (int f = 0; f < 6; f++) begin
            req = 2'($urandom_range(1, 3));
            sym_q.delete();
            repeat ($urandom_range(1, 12)) sym_q.push_back($urandom_range(0, 8));
            run_frame($sformatf("rnd%0d", f), 0, 1'b0);
        end

        // Reset in the middle of a stream
        req = 2'b01;
        for (int i = 0; i < 50 && gnt == 2'b00; i++) @(negedge clk);
        @(posedge clk) #1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, $urandom_range(1, 6), 1'b0);
            @(posedge clk) #1;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_core_reset", 32'(core_reset), 1);
        chk("midrst_gray_valid", 32'(core_gray_valid), 0);
        src_valid = '0;
        src_last  = '0;
        req       = '0;
        has_srv   = 1'b0;
        last_srv  = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Both requesting across three frames: 0, 1, 0
        req = 2'b11;
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("rr%0d_pick", f), 32'(pick(req)), 32'(f % 2));
            sym_q.delete();
            repeat ($urandom_range(2, 6)) sym_q.push_back($urandom_range(1, 6));
            run_frame($sformatf("rr%0d", f), 0, 1'b1);
        end
        req = 2'b00;

`ifdef HUFF_TIMEOUT_EN
        // code_valid never arrives: forced done 1023 cycles into WAIT_CODE
        @(negedge clk);
        req = 2'b01;
        sym_q = '{2, 4};
        run_frame("wdog", 2, 1'b0);
        chk("wdog_latency", 32'(done_wait), 1024);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
